// File: rtl/cpu_jtag_debug_scan_master_if.sv
// Command/response handshake bundle for the virtual-JTAG scan master.
// The scan master takes the slave view; a host or bench takes the master view.
interface cpu_jtag_debug_scan_master_if #(
  parameter int IR_WIDTH = 2,
  parameter int DR_WIDTH = 38
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [DR_WIDTH-1:0] cmd_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DR_WIDTH-1:0] rsp_data;
  logic [IR_WIDTH-1:0] rsp_ir_out;

  modport master (
    output cmd_valid, cmd_ir, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_ir_out
  );

  modport slave (
    input  cmd_valid, cmd_ir, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_ir_out
  );
endinterface

// File: rtl/cpu_jtag_debug_scan_master.sv
// Drives one UIR/CDR/SDR/UDR/RTI virtual-JTAG sequence per command.
// It returns the tdo bits captured during SDR and the ir_out value sampled in CDR.
module cpu_jtag_debug_scan_master #(
  parameter int IR_WIDTH = 2,
  parameter int DR_WIDTH = 38,
  parameter int TCK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset,
  cpu_jtag_debug_scan_master_if.slave bus,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [IR_WIDTH-1:0] ir_in,
  input  logic [IR_WIDTH-1:0] ir_out,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_UIR  = 3'd1;
  localparam logic [2:0] S_CDR  = 3'd2;
  localparam logic [2:0] S_SDR  = 3'd3;
  localparam logic [2:0] S_UDR  = 3'd4;
  localparam logic [2:0] S_RTI  = 3'd5;
  localparam logic [2:0] S_RESP = 3'd6;

  localparam int DW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam int BW = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TCK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DR_WIDTH - 1);

  logic [2:0]          state_q, state_d;
  logic [DW-1:0]       div_q, div_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic                tck_q, tck_d;
  logic                tdi_q, tdi_d;
  logic [DR_WIDTH-1:0] sr_q, sr_d;
  logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
  logic [IR_WIDTH-1:0] rsp_ir_q, rsp_ir_d;

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    tck_d    = tck_q;
    tdi_d    = tdi_q;
    sr_d     = sr_q;
    ir_in_d  = ir_in_q;
    rsp_ir_d = rsp_ir_q;
    case (state_q)
      S_IDLE: if (bus.cmd_valid) begin
        ir_in_d = bus.cmd_ir;
        sr_d    = bus.cmd_data;
        div_d   = '0;
        bit_d   = '0;
        tck_d   = 1'b0;
        state_d = S_UIR;
      end
      S_RESP: if (bus.rsp_ready) state_d = S_IDLE;
      default: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + 1'b1;
        end else if (!tck_q) begin
          // tck rising point: capture side of the period
          div_d = '0;
          tck_d = 1'b1;
          if (state_q == S_CDR) rsp_ir_d = ir_out;
          if (state_q == S_SDR) sr_d = {tdo, sr_q[DR_WIDTH-1:1]};
        end else begin
          // tck falling point: period boundary, state and tdi advance together
          div_d = '0;
          tck_d = 1'b0;
          case (state_q)
            S_UIR: state_d = S_CDR;
            S_CDR: state_d = S_SDR;
            S_SDR: if (bit_q == BIT_LAST) begin
              bit_d   = '0;
              state_d = S_UDR;
            end else begin
              bit_d = bit_q + 1'b1;
            end
            S_UDR:   state_d = S_RTI;
            default: state_d = S_RESP;
          endcase
          tdi_d = (state_d == S_SDR) ? sr_q[0] : 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      tck_q    <= 1'b0;
      tdi_q    <= 1'b0;
      sr_q     <= '0;
      ir_in_q  <= '0;
      rsp_ir_q <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      tck_q    <= tck_d;
      tdi_q    <= tdi_d;
      sr_q     <= sr_d;
      ir_in_q  <= ir_in_d;
      rsp_ir_q <= rsp_ir_d;
    end
  end

  assign tck            = tck_q;
  assign tdi            = tdi_q;
  assign ir_in          = ir_in_q;
  assign vs_uir         = (state_q == S_UIR);
  assign vs_cdr         = (state_q == S_CDR);
  assign vs_sdr         = (state_q == S_SDR);
  assign vs_udr         = (state_q == S_UDR);
  assign jtag_state_rti = (state_q == S_RTI);
  assign bus.cmd_ready  = (state_q == S_IDLE);
  assign bus.rsp_valid  = (state_q == S_RESP);
  assign bus.rsp_data   = sr_q;
  assign bus.rsp_ir_out = rsp_ir_q;
endmodule

// File: tb/tb_cpu_jtag_debug_scan_master.sv
// Scoreboard bench: a default-divider instance with a pattern-driven tdo model,
// and a TCK_DIV=1 instance with tdo looped back from tdi.
module tb_cpu_jtag_debug_scan_master;
  localparam int DW = 38;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cpu_jtag_debug_scan_master_if #(.IR_WIDTH(IW), .DR_WIDTH(DW)) bus0 ();
  cpu_jtag_debug_scan_master_if #(.IR_WIDTH(IW), .DR_WIDTH(DW)) bus1 ();

  logic          tck0, tdi0, tdo0, uir0, cdr0, sdr0, udr0, rti0;
  logic [IW-1:0] ir_in0, ir_out0;
  logic          tck1, tdi1, tdo1, uir1, cdr1, sdr1, udr1, rti1;
  logic [IW-1:0] ir_in1, ir_out1;

  cpu_jtag_debug_scan_master #(.IR_WIDTH(IW), .DR_WIDTH(DW), .TCK_DIV(4)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .tck(tck0), .tdi(tdi0), .tdo(tdo0),
    .ir_in(ir_in0), .ir_out(ir_out0), .vs_uir(uir0), .vs_cdr(cdr0), .vs_sdr(sdr0),
    .vs_udr(udr0), .jtag_state_rti(rti0)
  );

  cpu_jtag_debug_scan_master #(.IR_WIDTH(IW), .DR_WIDTH(DW), .TCK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .tck(tck1), .tdi(tdi1), .tdo(tdo1),
    .ir_in(ir_in1), .ir_out(ir_out1), .vs_uir(uir1), .vs_cdr(cdr1), .vs_sdr(sdr1),
    .vs_udr(udr1), .jtag_state_rti(rti1)
  );

  // Module model for dut0: tdo walks a pattern LSB first, one bit per SDR tck rise.
  logic [DW-1:0] tdo_pat = '0;
  logic [DW-1:0] tdi_seq = '0;
  logic [6:0]    sh_idx  = '0;
  always @(posedge tck0) begin
    if (cdr0) sh_idx <= '0;
    else if (sdr0) begin
      tdi_seq[sh_idx[5:0]] <= tdi0;
      sh_idx <= sh_idx + 7'd1;
    end
  end
  assign tdo0 = (sh_idx < 7'(DW)) ? tdo_pat[sh_idx[5:0]] : 1'b0;
  assign tdo1 = tdi1;

  int ovl_err = 0;
  always @(negedge clk) begin
    if (!$onehot0({uir0, cdr0, sdr0, udr0, rti0})) ovl_err <= ovl_err + 1;
    if (!$onehot0({uir1, cdr1, sdr1, udr1, rti1})) ovl_err <= ovl_err + 1;
  end

  typedef struct {
    logic [DW-1:0] d;
    logic [IW-1:0] ir;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic send0(input logic [IW-1:0] ir, input logic [DW-1:0] d,
                       input logic [DW-1:0] exp_d, input logic [IW-1:0] exp_ir,
                       output int acc);
    @(negedge clk);
    chk("idle_ready", bus0.cmd_ready, 1);
    bus0.cmd_ir    = ir;
    bus0.cmd_data  = d;
    bus0.cmd_valid = 1'b1;
    sb.push_back('{d: exp_d, ir: exp_ir});
    @(negedge clk);
    bus0.cmd_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_rsp0(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (bus0.rsp_valid) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
    if (at < 0) chk("rsp_timeout", 0, 1);
  endtask

  task automatic wait_shift0(input int n);
    int ok = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (sdr0 && sh_idx == 7'(n)) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) chk("shift_timeout", 0, 1);
  endtask

  task automatic pop_cmp(input string tag, input logic [DW-1:0] d, input logic [IW-1:0] ir);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_data"}, d, e.d);
      chk({tag, "_ir_out"}, ir, e.ir);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, at, stab_err, tog_err;
    logic [DW-1:0] d, pat;
    logic prev;
    reset = 1'b1;
    bus0.cmd_valid = 1'b0; bus0.cmd_ir = '0; bus0.cmd_data = '0; bus0.rsp_ready = 1'b0;
    bus1.cmd_valid = 1'b0; bus1.cmd_ir = '0; bus1.cmd_data = '0; bus1.rsp_ready = 1'b1;
    ir_out0 = '0; ir_out1 = 2'b01;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", bus0.cmd_ready, 1);
    chk("rst_tck", tck0, 0);
    chk("rst_strobes", {uir0, cdr0, sdr0, udr0, rti0}, 0);
    chk("rst_rsp_valid", bus0.rsp_valid, 0);
    chk("rst_ir_in", ir_in0, 0);
    chk("rst_tdi_rsp", {tdi0, bus0.rsp_data, bus0.rsp_ir_out}, 0);
    reset = 1'b0;

    // Single scan with back-pressure
    tdo_pat = 38'h15_5555_5555;
    ir_out0 = 2'b10;
    send0(2'b01, 38'h2A_AAAA_AAAA, 38'h15_5555_5555, 2'b10, acc);
    chk("c1_ir_in", ir_in0, 2'b01);
    chk("c1_uir_tck", {uir0, tck0}, 2'b10);
    repeat (3) @(negedge clk);
    chk("c4_tck_low", tck0, 0);
    @(negedge clk);
    chk("c5_tck_high", tck0, 1);
    wait_rsp0(400, at);
    chk("rsp_latency", at - acc, 336);
    chk("tdi_seq", tdi_seq, 38'h2A_AAAA_AAAA);
    pop_cmp("scan1", bus0.rsp_data, bus0.rsp_ir_out);
    d = bus0.rsp_data;
    stab_err = 0;
    repeat (10) begin
      @(negedge clk);
      if (!bus0.rsp_valid || bus0.rsp_data !== d || bus0.cmd_ready || tck0) stab_err++;
    end
    chk("bp_stable", stab_err, 0);
    bus0.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {bus0.cmd_ready, bus0.rsp_valid}, 2'b10);

    // Busy rejection mid-SDR
    pat = {$urandom, $urandom};
    d   = {$urandom, $urandom};
    tdo_pat = pat;
    ir_out0 = 2'b01;
    send0(2'b01, d, pat, 2'b01, acc);
    wait_shift0(5);
    bus0.cmd_ir = 2'b11; bus0.cmd_valid = 1'b1;
    @(negedge clk);
    bus0.cmd_valid = 1'b0;
    chk("busy_ready", bus0.cmd_ready, 0);
    chk("busy_ir_in", ir_in0, 2'b01);
    wait_rsp0(400, at);
    chk("busy_latency", at - acc, 336);
    chk("busy_tdi_seq", tdi_seq, d);
    pop_cmp("busy", bus0.rsp_data, bus0.rsp_ir_out);
    @(negedge clk);
    chk("one_cycle_rsp", {bus0.cmd_ready, bus0.rsp_valid}, 2'b10);
    chk("ir_in_kept", ir_in0, 2'b01);

    // Reset mid-SDR, then a fresh scan
    tdo_pat = {$urandom, $urandom};
    send0(2'b10, {$urandom, $urandom}, tdo_pat, 2'b01, acc);
    wait_shift0(20);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_ctl", {bus0.cmd_ready, bus0.rsp_valid, tck0, tdi0}, 4'b1000);
    chk("midrst_strobes", {uir0, cdr0, sdr0, udr0, rti0}, 0);
    chk("midrst_regs", {ir_in0, bus0.rsp_ir_out, bus0.rsp_data}, 0);
    reset = 1'b0;
    void'(sb.pop_front());
    tdo_pat = '1;
    ir_out0 = 2'b11;
    send0(2'b00, 38'h0, 38'h3F_FFFF_FFFF, 2'b11, acc);
    wait_rsp0(400, at);
    chk("fresh_latency", at - acc, 336);
    pop_cmp("fresh", bus0.rsp_data, bus0.rsp_ir_out);

    // TCK_DIV=1 with loopback
    d = {$urandom, $urandom};
    @(negedge clk);
    chk("d1_ready", bus1.cmd_ready, 1);
    bus1.cmd_ir = 2'b10; bus1.cmd_data = d; bus1.cmd_valid = 1'b1;
    sb.push_back('{d: d, ir: 2'b01});
    @(negedge clk);
    bus1.cmd_valid = 1'b0;
    acc = cyc;
    chk("d1_c1_tck", tck1, 0);
    prev = tck1;
    tog_err = 0;
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus1.rsp_valid) begin
        at = cyc;
        break;
      end
      if (tck1 === prev) tog_err++;
      prev = tck1;
    end
    chk("d1_latency", at - acc, 84);
    chk("d1_toggle", tog_err, 0);
    chk("d1_ir_in", ir_in1, 2'b10);
    pop_cmp("d1", bus1.rsp_data, bus1.rsp_ir_out);
    @(negedge clk);
    chk("d1_done", {bus1.cmd_ready, bus1.rsp_valid}, 2'b10);

    chk("strobe_onehot", ovl_err, 0);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
